// File: rtl/quad_step_decoder.sv
// Quadrature rotary-encoder front end: two-flop sync, per-channel stability filter,
// Gray-code decode with detent accumulation, one-cycle STEP/ERR pulses and a wrapping position.
module quad_step_decoder #(
  parameter int unsigned FILTER_CYCLES    = 16000,
  parameter int unsigned STEPS_PER_DETENT = 4,
  parameter int unsigned POS_W            = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENC_A,
  input  logic             ENC_B,
  output logic             STEP,
  output logic             DIR,
  output logic [POS_W-1:0] POS,
  output logic             ERR
);

  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 2);
  localparam logic [CntW-1:0] FiltLast  = CntW'(FILTER_CYCLES - 1);
  localparam logic [CntW-1:0] PrimeLast = CntW'(FILTER_CYCLES + 1);
  localparam int SpdI = int'(STEPS_PER_DETENT);

  typedef enum logic [0:0] {StPrime, StTrack} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        prime_cnt_q, prime_cnt_d;
  logic [1:0]             s1_q, s1_d, s2_q, s2_d;
  logic [1:0]             filt_q, filt_d, prev_q, prev_d;
  logic [CntW-1:0]        filt_cnt_q [2];
  logic [CntW-1:0]        filt_cnt_d [2];
  logic signed [3:0]      acc_q, acc_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic [1:0]             diff;
  int                     sum;

  // Map {A,B} Gray code onto a 0..3 ring so CW motion is +1 modulo 4.
  function automatic logic [1:0] gray2idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= StPrime;
      prime_cnt_q <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      filt_q      <= '0;
      prev_q      <= '0;
      filt_cnt_q  <= '{default: '0};
      acc_q       <= '0;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      filt_q      <= filt_d;
      prev_q      <= prev_d;
      filt_cnt_q  <= filt_cnt_d;
      acc_q       <= acc_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    s1_d        = {ENC_A, ENC_B};
    s2_d        = s1_q;
    filt_d      = filt_q;
    prev_d      = prev_q;
    filt_cnt_d  = filt_cnt_q;
    acc_d       = acc_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    err_d       = 1'b0;
    diff        = 2'(gray2idx(filt_q) - gray2idx(prev_q));
    sum         = int'(acc_q);

    unique case (state_q)
      StPrime: begin
        filt_cnt_d = '{default: '0};
        // Adopt whatever level the pins rest at, so a non-00 rest produces no step.
        if (prime_cnt_q == PrimeLast) begin
          state_d     = StTrack;
          prime_cnt_d = '0;
          filt_d      = s2_q;
          prev_d      = s2_q;
          acc_d       = '0;
        end else begin
          prime_cnt_d = prime_cnt_q + 1'b1;
        end
      end

      StTrack: begin
        for (int i = 0; i < 2; i++) begin
          if (s2_q[i] == filt_q[i]) begin
            filt_cnt_d[i] = '0;
          end else if (filt_cnt_q[i] == FiltLast) begin
            filt_d[i]     = s2_q[i];
            filt_cnt_d[i] = '0;
          end else begin
            filt_cnt_d[i] = filt_cnt_q[i] + 1'b1;
          end
        end

        prev_d = filt_q;
        case (diff)
          2'd1: sum = int'(acc_q) + 1;
          2'd3: sum = int'(acc_q) - 1;
          2'd2: begin
            err_d = 1'b1;
            acc_d = '0;
          end
          default: ;
        endcase

        if (diff == 2'd1 || diff == 2'd3) begin
          if (sum == SpdI) begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            pos_d  = pos_q + POS_W'(1);
            acc_d  = '0;
          end else if (sum == -SpdI) begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            pos_d  = pos_q - POS_W'(1);
            acc_d  = '0;
          end else begin
            acc_d = 4'(sum);
          end
        end
      end

      default: state_d = StPrime;
    endcase
  end

  assign STEP = step_q;
  assign DIR  = dir_q;
  assign POS  = pos_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with FILTER_CYCLES=4, STEPS_PER_DETENT=4, POS_W=8.
module tb_quad_step_decoder;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       ENC_A = 1'b1;
  logic       ENC_B = 1'b1;
  logic       STEP, DIR, ERR;
  logic [7:0] POS;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int step_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_step_edge = -1;
  int set_edge = 0;
  int s0, e0;

  quad_step_decoder #(
    .FILTER_CYCLES   (4),
    .STEPS_PER_DETENT(4),
    .POS_W           (8)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .ENC_A(ENC_A),
    .ENC_B(ENC_B),
    .STEP (STEP),
    .DIR  (DIR),
    .POS  (POS),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_n <= edge_n + 1;

  always @(negedge CLK) begin
    if (STEP === 1'b1) begin
      step_cnt       <= step_cnt + 1;
      last_step_edge <= edge_n;
    end
    if (ERR === 1'b1) err_cnt <= err_cnt + 1;
    if (STEP === 1'b1 && ERR === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    @(negedge CLK);
    ENC_A    = a;
    ENC_B    = b;
    set_edge = edge_n;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (n) @(negedge CLK);
    check("rst_step", 32'(STEP), 0);
    check("rst_err", 32'(ERR), 0);
    check("rst_pos", 32'(POS), 0);
    check("rst_dir", 32'(DIR), 0);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
  endtask

  initial begin
    // Power-up reset with the pins resting at 11.
    repeat (3) @(negedge CLK);
    check("init_step", 32'(STEP), 0);
    check("init_err", 32'(ERR), 0);
    check("init_pos", 32'(POS), 0);
    check("init_dir", 32'(DIR), 0);
    RST_N = 1'b1;
    hold(1, 1, 100);
    check("rest11_steps", 32'(step_cnt), 0);
    check("rest11_errs", 32'(err_cnt), 0);
    check("rest11_pos", 32'(POS), 0);
    check("rest11_dir", 32'(DIR), 0);

    // Re-prime with pins at 00, then one CW detent.
    hold(0, 0, 5);
    do_reset(2);
    s0 = step_cnt; e0 = err_cnt;
    hold(0, 1, 20);
    hold(1, 1, 20);
    hold(1, 0, 20);
    hold(0, 0, 20);
    check("cw_latency", 32'(last_step_edge - set_edge), 7);
    check("cw_steps", 32'(step_cnt - s0), 1);
    check("cw_errs", 32'(err_cnt - e0), 0);
    check("cw_dir", 32'(DIR), 1);
    check("cw_pos", 32'(POS), 1);

    // CCW detent from POS=0 wraps to 255.
    do_reset(2);
    s0 = step_cnt; e0 = err_cnt;
    hold(1, 0, 20);
    hold(1, 1, 20);
    hold(0, 1, 20);
    hold(0, 0, 20);
    check("ccw_steps", 32'(step_cnt - s0), 1);
    check("ccw_dir", 32'(DIR), 0);
    check("ccw_pos", 32'(POS), 255);

    // Three-clock glitch on A is rejected by the four-clock filter.
    s0 = step_cnt; e0 = err_cnt;
    hold(1, 0, 3);
    hold(0, 0, 20);
    check("glitch_steps", 32'(step_cnt - s0), 0);
    check("glitch_errs", 32'(err_cnt - e0), 0);
    check("glitch_pos", 32'(POS), 255);

    // Both pins jump at once: one ERR, no STEP.
    s0 = step_cnt; e0 = err_cnt;
    hold(1, 1, 20);
    check("illegal_errs", 32'(err_cnt - e0), 1);
    check("illegal_steps", 32'(step_cnt - s0), 0);
    check("illegal_pos", 32'(POS), 255);

    // Full CW detent from 11 wraps 255 -> 0.
    s0 = step_cnt; e0 = err_cnt;
    hold(1, 0, 20);
    hold(0, 0, 20);
    hold(0, 1, 20);
    hold(1, 1, 20);
    check("cw11_steps", 32'(step_cnt - s0), 1);
    check("cw11_pos", 32'(POS), 0);
    check("cw11_dir", 32'(DIR), 1);
    check("cw11_latency", 32'(last_step_edge - set_edge), 7);

    // Two quarter-steps forward then back: no STEP, accumulator back to 0.
    s0 = step_cnt;
    hold(1, 0, 20);
    hold(0, 0, 20);
    hold(1, 0, 20);
    hold(1, 1, 20);
    check("reverse_steps", 32'(step_cnt - s0), 0);
    check("reverse_pos", 32'(POS), 0);
    hold(1, 0, 20);
    hold(0, 0, 20);
    hold(0, 1, 20);
    check("after_rev_partial", 32'(step_cnt - s0), 0);
    hold(1, 1, 20);
    check("after_rev_steps", 32'(step_cnt - s0), 1);
    check("after_rev_pos", 32'(POS), 1);

    // Half a detent, one-clock reset, then the other half: no STEP.
    hold(1, 0, 20);
    hold(0, 0, 20);
    do_reset(1);
    s0 = step_cnt; e0 = err_cnt;
    hold(0, 1, 20);
    hold(1, 1, 20);
    check("rstmid_steps", 32'(step_cnt - s0), 0);
    check("rstmid_errs", 32'(err_cnt - e0), 0);
    check("rstmid_pos", 32'(POS), 0);
    check("rstmid_dir", 32'(DIR), 0);

    check("step_err_overlap", 32'(both_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
